// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port synchronous RAM between instruction
//            fetch (IF, read-only) and load/store (LS, read/write).
//            Transactions are serialised through IDLE -> ISSUE -> WAIT ->
//            RESP. The owner receives a one-cycle ready pulse with
//            registered read data.
// Options  : ARB_ROUND_ROBIN_EN - when defined, contention alternates
//            between the ports. When undefined, LS has fixed priority
//            over IF.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  sysclk,
    input  logic                  nrst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_ready,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [DATA_W/8-1:0]   ls_be,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic [DATA_W-1:0]     ls_wdata,
    output logic                  ls_ready,
    output logic [DATA_W-1:0]     ls_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    // Four counter bits cover the full legal latency range of 1..15
    localparam int              CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             owner_ls;
    logic             grant_ls;
    logic             any_req;
    logic             grant;
    logic             rd_capture;

    assign any_req    = if_req | ls_req;
    assign grant      = (state == S_IDLE) && any_req;
    assign rd_capture = (state == S_WAIT) && (cnt == '0) && !mem_we;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_ls;

    // On contention the port that was not granted last wins; a lone requester always wins
    assign grant_ls = ls_req & (~if_req | ~last_ls);

    // Remember which port received the most recent grant (reset favours LS first)
    always_ff @(posedge sysclk or negedge nrst) begin
        if (!nrst) begin
            last_ls <= 1'b0;
        end else if (grant) begin
            last_ls <= grant_ls;
        end
    end
`else
    // Fixed priority: LS always beats IF
    assign grant_ls = ls_req;
`endif

    // State register
    always_ff @(posedge sysclk or negedge nrst) begin
        if (!nrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: fixed walk through the four phases of a transaction
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_req) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (cnt == '0) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: RAM strobe in ISSUE, owner's ready pulse in RESP
    always_comb begin
        mem_en   = (state == S_ISSUE);
        if_ready = (state == S_RESP) && !owner_ls;
        ls_ready = (state == S_RESP) &&  owner_ls;
    end

    // Latch owner and its fields at grant; they drive the RAM port until the next grant
    always_ff @(posedge sysclk or negedge nrst) begin
        if (!nrst) begin
            owner_ls  <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant) begin
            owner_ls <= grant_ls;
            if (grant_ls) begin
                mem_we    <= ls_we;
                mem_be    <= ls_be;
                mem_addr  <= ls_addr;
                mem_wdata <= ls_wdata;
            end else begin
                mem_we    <= 1'b0;
                mem_be    <= '1;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end
        end
    end

    // Latency counter: loaded as the RAM samples the strobe, counts down in WAIT
    always_ff @(posedge sysclk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (state == S_ISSUE) begin
            cnt <= CNT_LOAD;
        end else if ((state == S_WAIT) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Capture read data into the owner's register only; writes leave both untouched
    always_ff @(posedge sysclk or negedge nrst) begin
        if (!nrst) begin
            if_rdata <= '0;
            ls_rdata <= '0;
        end else if (rd_capture) begin
            if (owner_ls) begin
                ls_rdata <= mem_rdata;
            end else begin
                if_rdata <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. Drives both ports
//            against a behavioural RAM and scores RAM accesses and ready
//            pulses against expected transactions queued at stimulus time.
// Options  : ARB_ROUND_ROBIN_EN selects the expected contention order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int LAT  = 1;
    localparam int LAT4 = 4;

    logic sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    logic        nrst;
    logic        if_req, if_ready, ls_req, ls_we, ls_ready;
    logic [31:0] if_addr, if_rdata, ls_addr, ls_wdata, ls_rdata;
    logic [3:0]  ls_be, mem_be;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    // Second instance exercising a longer RAM latency
    logic        if_req4, if_ready4, ls_ready4, mem_en4, mem_we4;
    logic [31:0] if_addr4, if_rdata4, ls_rdata4, mem_addr4, mem_wdata4, mem_rdata4;
    logic [3:0]  mem_be4;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) dut (
        .sysclk(sysclk), .nrst(nrst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT4)) dut4 (
        .sysclk(sysclk), .nrst(nrst),
        .if_req(if_req4), .if_addr(if_addr4), .if_ready(if_ready4), .if_rdata(if_rdata4),
        .ls_req(1'b0), .ls_we(1'b0), .ls_be(4'h0), .ls_addr(32'h0),
        .ls_wdata(32'h0), .ls_ready(ls_ready4), .ls_rdata(ls_rdata4),
        .mem_en(mem_en4), .mem_we(mem_we4), .mem_be(mem_be4), .mem_addr(mem_addr4),
        .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata4)
    );

    // ---------------- behavioural RAMs ----------------
    bit [31:0] ram [0:1023];
    bit        ram_loaded;
    bit [31:0] rd_q;

    always @(posedge sysclk) begin
        if (!ram_loaded) begin
            ram[64]    <= 32'h00A00093;
            ram_loaded <= 1'b1;
        end
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                rd_q <= ram[mem_addr[11:2]];
            end
        end
    end
    assign mem_rdata = rd_q;

    bit [31:0] p4 [0:3];
    always @(posedge sysclk) begin
        if (mem_en4) p4[0] <= mem_addr4 ^ 32'h5A5A_0000;
        p4[1] <= p4[0];
        p4[2] <= p4[1];
        p4[3] <= p4[2];
    end
    assign mem_rdata4 = p4[3];

    // ---------------- scoreboard ----------------
    typedef struct { bit is_ls; bit we; bit [31:0] data; } resp_t;
    typedef struct { bit we; bit [3:0] be; bit [31:0] addr; bit [31:0] wdata; } iss_t;

    resp_t     resp_q[$];
    iss_t      iss_q[$];
    bit [31:0] model_mem [bit [31:0]];
    int        n_cmp, n_err;
    int        cyc, ready_cnt, ready_cyc, en_run, en4_cnt;
    int        en_cyc[$];
    bit [31:0] held_ls, held_if;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    function automatic bit [31:0] model_rd(input bit [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : 32'h0;
    endfunction

    task automatic expect_txn(input bit ls, input bit we, input bit [3:0] be,
                              input bit [31:0] addr, input bit [31:0] wdata);
        iss_t      s;
        resp_t     r;
        bit [31:0] w;
        s.we = we; s.be = ls ? be : 4'hF; s.addr = addr; s.wdata = wdata;
        iss_q.push_back(s);
        r.is_ls = ls; r.we = we; r.data = 32'h0;
        if (we) begin
            w = model_rd(addr);
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
            model_mem[addr] = w;
        end else begin
            r.data = model_rd(addr);
        end
        resp_q.push_back(r);
    endtask

    always @(posedge sysclk) cyc <= cyc + 1;

    // Monitor: scores every RAM strobe and every ready pulse
    initial begin
        resp_t r;
        iss_t  s;
        forever begin
            @(negedge sysclk);
            if (nrst) begin
                if (mem_en) begin
                    en_run++;
                    en_cyc.push_back(cyc);
                    if (iss_q.size() == 0) check("spurious_mem_en", 1, 0);
                    else begin
                        s = iss_q.pop_front();
                        check("mem_addr", mem_addr, s.addr);
                        check("mem_be", mem_be, s.be);
                        check("mem_we", mem_we, s.we);
                        if (s.we) check("mem_wdata", mem_wdata, s.wdata);
                    end
                end else if (en_run != 0) begin
                    check("mem_en_len", en_run, 1);
                    en_run = 0;
                end
                if (if_ready || ls_ready) begin
                    ready_cnt++;
                    ready_cyc = cyc;
                    if (resp_q.size() == 0) check("spurious_ready", 1, 0);
                    else begin
                        r = resp_q.pop_front();
                        check("ready_port", {if_ready, ls_ready}, r.is_ls ? 2'b01 : 2'b10);
                        if (r.is_ls) begin
                            if (!r.we) held_ls = r.data;
                            check("ls_rdata", ls_rdata, held_ls);
                            check("if_rdata_hold", if_rdata, held_if);
                        end else begin
                            held_if = r.data;
                            check("if_rdata", if_rdata, held_if);
                            check("ls_rdata_hold", ls_rdata, held_ls);
                        end
                    end
                end
            end else begin
                en_run = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge sysclk);
            if (nrst && mem_en4) en4_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ready(input int target, input int budget);
        int n = 0;
        while (ready_cnt < target && n < budget) begin
            @(negedge sysclk); #1;
            n++;
        end
        if (ready_cnt < target) check("ready_timeout", ready_cnt, target);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {mem_en, mem_we, if_ready, ls_ready, mem_be}, 8'h0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_if_rdata"}, if_rdata, 0);
        check({tag, "_ls_rdata"}, ls_rdata, 0);
    endtask

    task automatic do_txn(input bit ls, input bit we, input bit [3:0] be,
                          input bit [31:0] addr, input bit [31:0] wdata, input bit early_drop);
        int start;
        expect_txn(ls, we, be, addr, wdata);
        @(posedge sysclk); #2;
        if (ls) begin
            ls_req = 1'b1; ls_we = we; ls_be = be; ls_addr = addr; ls_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        start = cyc;
        if (early_drop) begin
            @(posedge sysclk); #2;
            if_req = 1'b0; ls_req = 1'b0;
        end
        wait_ready(ready_cnt + 1, 40);
        if_req = 1'b0; ls_req = 1'b0;
        check("latency", ready_cyc - start, LAT + 2);
    endtask

    task automatic pulse_reset();
        @(posedge sysclk); #2;
        nrst = 1'b0;
        resp_q.delete(); iss_q.delete();
        held_ls = 32'h0; held_if = 32'h0;
        @(posedge sysclk); #2;
        nrst = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int start, lat;
        bit rdy;
        nrst = 1'b0;
        if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_be = 0; ls_addr = 0; ls_wdata = 0;
        if_req4 = 0; if_addr4 = 0;
        model_mem[32'h100] = 32'h00A00093;
        repeat (3) @(posedge sysclk);
        #2;
        check_zero("reset");
        nrst = 1'b1;

        // IF read, LS read, LS partial write, read-back, IF read
        do_txn(0, 0, 4'hF, 32'h100, 32'h0, 0);
        do_txn(1, 0, 4'hF, 32'h100, 32'h0, 0);
        do_txn(1, 1, 4'b0011, 32'h200, 32'hDEADBEEF, 0);
        do_txn(1, 0, 4'hF, 32'h200, 32'h0, 0);
        do_txn(0, 0, 4'hF, 32'h200, 32'h0, 0);
        // owner drops its request early; transaction still completes
        do_txn(1, 0, 4'hF, 32'h100, 32'h0, 1);

        // Asynchronous reset in the middle of WAIT
        expect_txn(1, 0, 4'hF, 32'h100, 32'h0);
        @(posedge sysclk); #2;
        ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h100;
        @(posedge sysclk);
        @(posedge sysclk); #2;
        nrst = 1'b0; #1;
        check_zero("mid_rst");
        resp_q.delete(); iss_q.delete();
        held_ls = 32'h0; held_if = 32'h0;
        @(posedge sysclk); #2;
        nrst = 1'b1;
        expect_txn(1, 0, 4'hF, 32'h100, 32'h0);
        start = cyc;
        wait_ready(ready_cnt + 1, 40);
        ls_req = 1'b0;
        check("rearb_latency", ready_cyc - start, LAT + 2);

        // Contention from a fresh reset
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (k % 2 == 0) expect_txn(1, 0, 4'hF, 32'h200, 32'h0);
            else            expect_txn(0, 0, 4'hF, 32'h100, 32'h0);
`else
            expect_txn(1, 0, 4'hF, 32'h200, 32'h0);
`endif
        end
        @(posedge sysclk); #2;
        ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h200;
        if_req = 1'b1; if_addr = 32'h100;
        wait_ready(ready_cnt + 4, 100);
        ls_req = 1'b0; if_req = 1'b0;
        repeat (4) @(posedge sysclk);
        check("contention_drain", resp_q.size() + iss_q.size(), 0);

        // Back-to-back LS reads with the request held across ready
        en_cyc.delete();
        expect_txn(1, 0, 4'hF, 32'h100, 32'h0);
        expect_txn(1, 0, 4'hF, 32'h200, 32'h0);
        @(posedge sysclk); #2;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100;
        wait_ready(ready_cnt + 1, 40);
        ls_addr = 32'h200;
        wait_ready(ready_cnt + 1, 40);
        ls_req = 1'b0;
        check("b2b_en_count", en_cyc.size(), 2);
        if (en_cyc.size() >= 2) check("b2b_gap", en_cyc[1] - en_cyc[0], 4);

        // Longer RAM latency on the second instance
        en4_cnt = 0;
        @(posedge sysclk); #2;
        if_addr4 = 32'h40; if_req4 = 1'b1;
        start = cyc; lat = -1; rdy = 1'b0;
        for (int n = 0; n < 40 && !rdy; n++) begin
            @(negedge sysclk); #1;
            if (if_ready4) begin rdy = 1'b1; lat = cyc - start; end
        end
        if_req4 = 1'b0;
        check("lat4", lat, LAT4 + 2);
        check("rdata4", if_rdata4, 32'h40 ^ 32'h5A5A_0000);
        check("be4", mem_be4, 4'hF);
        repeat (4) @(posedge sysclk);
        #2;
        check("en4_pulses", en4_cnt, 1);
        check("ls_side4_idle", {ls_ready4, mem_we4, ls_rdata4, mem_wdata4}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
